// File: rtl/button_ctrl_n.sv
// Multi-channel button front end: sync, sampled debounce, press/release/long/repeat pulses, clock-mode FSM.
// Latency: 2 sync cycles + DEBOUNCE_SAMPLES ticks to btn_state; mode follows pulses by 1 cycle. No backpressure.
module button_ctrl_n #(
  parameter int N_BTN            = 4,
  parameter int ACTIVE_LOW       = 1,
  parameter int SAMPLE_DIV       = 100000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int LONG_SAMPLES     = 100,
  parameter int REPEAT_SAMPLES   = 20,
  parameter int SET_IDX          = 2,
  parameter int ALARM_IDX        = 3
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [1:0]       clk_mode
);

  localparam int DW = $clog2(SAMPLE_DIV + 1);
  localparam int AW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int HW = $clog2(LONG_SAMPLES + 1);
  localparam int RW = (REPEAT_SAMPLES > 0) ? $clog2(REPEAT_SAMPLES + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] DEB_MAX  = AW'(DEBOUNCE_SAMPLES);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_SAMPLES);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_SAMPLES);
  // Synchroniser idle value is the pad level of an unpressed button.
  localparam logic [N_BTN-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_HOURS   = 2'd1,
    MODE_MINUTES = 2'd2,
    MODE_ALARM   = 2'd3
  } mode_t;

  logic [N_BTN-1:0] sync1, sync2, s, flip;
  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic [AW-1:0]    agree [N_BTN];
  logic [HW-1:0]    hold  [N_BTN];
  logic [RW-1:0]    rep   [N_BTN];
  mode_t            mode, mode_nxt;

  assign s    = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign tick = (div_cnt == DIV_LAST);

  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++)
      flip[i] = tick && (s[i] != btn_state[i]) && ((agree[i] + 1'b1) == DEB_MAX);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= IDLE_LVL;
      sync2         <= IDLE_LVL;
      div_cnt       <= '0;
      btn_state     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        agree[i] <= '0;
        hold[i]  <= '0;
        rep[i]   <= '0;
      end
    end else begin
      sync1         <= btn_raw;
      sync2         <= sync1;
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      press_pulse   <= flip & ~btn_state;
      release_pulse <= flip & btn_state;
      btn_state     <= btn_state ^ flip;
      long_pulse    <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (tick)
          agree[i] <= ((s[i] == btn_state[i]) || flip[i]) ? '0 : agree[i] + 1'b1;
        // Counting runs only while already pressed; press and release ticks both clear.
        if (!btn_state[i] || flip[i]) begin
          hold[i] <= '0;
          rep[i]  <= '0;
        end else if (tick) begin
          if (hold[i] != LONG_MAX) begin
            hold[i] <= hold[i] + 1'b1;
            if ((hold[i] + 1'b1) == LONG_MAX)
              long_pulse[i] <= 1'b1;
          end else if (REPEAT_SAMPLES > 0) begin
            if ((rep[i] + 1'b1) == REP_MAX) begin
              repeat_pulse[i] <= 1'b1;
              rep[i]          <= '0;
            end else begin
              rep[i] <= rep[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) mode <= MODE_RUN;
    else        mode <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode;
    // Simultaneous SET and ALARM presses cancel each other.
    if (!(press_pulse[SET_IDX] && press_pulse[ALARM_IDX])) begin
      if (press_pulse[SET_IDX]) begin
        case (mode)
          MODE_RUN:     mode_nxt = MODE_HOURS;
          MODE_HOURS:   mode_nxt = MODE_MINUTES;
          MODE_MINUTES: mode_nxt = MODE_RUN;
          default:      mode_nxt = mode;
        endcase
      end else if (press_pulse[ALARM_IDX]) begin
        if (mode == MODE_RUN)        mode_nxt = MODE_ALARM;
        else if (mode == MODE_ALARM) mode_nxt = MODE_RUN;
      end else if (long_pulse[SET_IDX] && (mode == MODE_HOURS || mode == MODE_MINUTES)) begin
        mode_nxt = MODE_RUN;
      end
    end
  end

  assign clk_mode = mode;

endmodule
